// File: rtl/serial_transmitter.sv
// Serial frame transmitter: start, 7 data bits LSB first, pad, even parity, idle gap.
// A one-entry holding buffer lets the host queue the next word during a frame.
module serial_transmitter #(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] data_in,
    input  logic       force_parity_err,
    input  logic       valid,
    output logic       ready,
    output logic       serial_out,
    output logic       busy,
    output logic [2:0] state_dbg
);

    localparam int MAX_CNT = (CLKS_PER_BIT > GAP_CYCLES) ? CLKS_PER_BIT : GAP_CYCLES;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam logic [CW-1:0] SLOT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PAD    = 3'd3,
        PARITY = 3'd4,
        GAP    = 3'd5
    } state_t;

    // Handshake: a word is taken at a rising edge where valid && ready;
    // ready is low exactly while the holding buffer is occupied.

    state_t          state, state_n;
    logic [7:0]      shreg, shreg_n;
    logic [2:0]      bit_cnt, bit_n;
    logic [CW-1:0]   div_cnt, div_n;
    logic            hold_valid, hold_valid_n;
    logic [7:0]      hold_word, hold_word_n;
    logic            line_n;
    logic            accept;
    logic            slot_last;
    logic            gap_last;

    // Shift register image {parity, data}; word[7] is the parity-inversion flag.
    function automatic logic [7:0] frame_load(input logic [7:0] word);
        return {(^word[6:0]) ^ word[7], word[6:0]};
    endfunction

    assign ready     = !hold_valid;
    assign accept    = valid && ready;
    assign slot_last = (div_cnt == SLOT_LAST);
    assign gap_last  = (div_cnt == GAP_LAST);
    assign state_dbg = state;

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        bit_n        = bit_cnt;
        div_n        = div_cnt;
        hold_valid_n = hold_valid;
        hold_word_n  = hold_word;
        line_n       = 1'b1;

        if (accept && state != IDLE) begin
            hold_valid_n = 1'b1;
            hold_word_n  = {force_parity_err, data_in};
        end

        case (state)
            IDLE: begin
                if (hold_valid) begin
                    shreg_n      = frame_load(hold_word);
                    hold_valid_n = 1'b0;
                    state_n      = START;
                    div_n        = '0;
                    bit_n        = '0;
                end else if (accept) begin
                    shreg_n = frame_load({force_parity_err, data_in});
                    state_n = START;
                    div_n   = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (slot_last) begin
                    state_n = DATA;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + CW'(1);
                end
            end
            DATA: begin
                if (slot_last) begin
                    div_n   = '0;
                    shreg_n = {1'b0, shreg[7:1]};
                    if (bit_cnt == 3'd6) begin
                        state_n = PAD;
                        bit_n   = '0;
                    end else begin
                        bit_n = bit_cnt + 3'd1;
                    end
                end else begin
                    div_n = div_cnt + CW'(1);
                end
            end
            PAD: begin
                if (slot_last) begin
                    state_n = PARITY;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + CW'(1);
                end
            end
            PARITY: begin
                if (slot_last) begin
                    state_n = GAP;
                    div_n   = '0;
                end else begin
                    div_n = div_cnt + CW'(1);
                end
            end
            GAP: begin
                if (gap_last) begin
                    div_n = '0;
                    if (hold_valid) begin
                        shreg_n      = frame_load(hold_word);
                        hold_valid_n = 1'b0;
                        state_n      = START;
                        bit_n        = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div_cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        // After the data shifts, parity sits in shreg[0] for the PARITY slot.
        case (state_n)
            START:   line_n = 1'b0;
            DATA:    line_n = shreg_n[0];
            PAD:     line_n = 1'b0;
            PARITY:  line_n = shreg_n[0];
            default: line_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            hold_valid <= 1'b0;
            hold_word  <= '0;
            serial_out <= 1'b1;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_n;
            div_cnt    <= div_n;
            hold_valid <= hold_valid_n;
            hold_word  <= hold_word_n;
            serial_out <= line_n;
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_serial_transmitter.sv
// Bench for serial_transmitter: directed and random words checked against a frame
// model and a receiver model; one instance at defaults, one at 3 clocks/bit, 2 gap.
module tb_serial_transmitter;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] data_in;
    logic       fpe;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       so_a, so_b;
    logic       busy_a, busy_b;
    logic [2:0] st_a, st_b;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [6:0] rx_d;
    logic       rx_p;

    always #5 clk = ~clk;

    serial_transmitter #(.CLKS_PER_BIT(1), .GAP_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_in), .force_parity_err(fpe),
        .valid(valid_a), .ready(ready_a), .serial_out(so_a), .busy(busy_a),
        .state_dbg(st_a)
    );

    serial_transmitter #(.CLKS_PER_BIT(3), .GAP_CYCLES(2)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in), .force_parity_err(fpe),
        .valid(valid_b), .ready(ready_b), .serial_out(so_b), .busy(busy_b),
        .state_dbg(st_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic line(input bit sel);
        return sel ? so_b : so_a;
    endfunction

    function automatic logic bsy(input bit sel);
        return sel ? busy_b : busy_a;
    endfunction

    // Driver: offer a word, hold it until taken, then drop valid just after that edge.
    task automatic host_send(input bit sel, input logic [6:0] d, input logic f, input string tag);
        bit done;
        done = 1'b0;
        data_in = d;
        fpe = f;
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        for (int i = 0; i < 64 && !done; i++) begin
            if ((sel ? ready_b : ready_a) === 1'b1) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        chk({tag, " accept"}, 32'(done), 32'd1);
    endtask

    // Frame model: expected line bits for one frame, then a receiver decode of the captured bits.
    task automatic watch_frame(input bit sel, input logic [6:0] d, input logic f,
                               input int cpb, input int gap, input int limit, input string tag);
        logic exp_bits[$];
        logic got[$];
        logic par;
        bit   seen;
        par = ((($countones(d) % 2) != 0) ? 1'b1 : 1'b0) ^ f;
        for (int s = 0; s < cpb; s++) exp_bits.push_back(1'b0);
        for (int i = 0; i < 7; i++)
            for (int s = 0; s < cpb; s++) exp_bits.push_back(d[i]);
        for (int s = 0; s < cpb; s++) exp_bits.push_back(1'b0);
        for (int s = 0; s < cpb; s++) exp_bits.push_back(par);
        for (int s = 0; s < gap; s++) exp_bits.push_back(1'b1);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (line(sel) === 1'b0) seen = 1'b1;
        end
        chk({tag, " start"}, 32'(seen), 32'd1);
        if (seen) begin
            for (int i = 0; i < exp_bits.size(); i++) begin
                if (i > 0) @(negedge clk);
                got.push_back(line(sel));
                chk($sformatf("%s bit%0d", tag, i), 32'(line(sel)), 32'(exp_bits[i]));
                chk($sformatf("%s busy%0d", tag, i), 32'(bsy(sel)), 32'd1);
            end
            for (int i = 0; i < 7; i++) rx_d[i] = got[(1 + i) * cpb + cpb / 2];
            rx_p = got[9 * cpb + cpb / 2] ^ (^rx_d);
        end else begin
            rx_d = 'x;
            rx_p = 1'bx;
        end
    endtask

    task automatic sb_check(input string tag);
        logic [7:0] e;
        chk({tag, " sb nonempty"}, 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, " rx data"}, 32'(rx_d), 32'(e[6:0]));
            chk({tag, " rx parity_ok_n"}, 32'(rx_p), 32'(e[7]));
        end
    endtask

    // Two words with valid held: second goes into the buffer during the first frame.
    task automatic send_pair(input logic [6:0] d1, input logic f1,
                             input logic [6:0] d2, input logic f2, input string tag);
        exp_q.push_back({f1, d1});
        exp_q.push_back({f2, d2});
        fork
            begin
                host_send(1'b0, d1, f1, {tag, " w1"});
                host_send(1'b0, d2, f2, {tag, " w2"});
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    chk($sformatf("%s ready low%0d", tag, i), 32'(ready_a), 32'd0);
                end
                @(negedge clk);
                chk({tag, " ready after drain"}, 32'(ready_a), 32'd1);
            end
            begin
                watch_frame(1'b0, d1, f1, 1, 1, 4, {tag, " f1"});
                sb_check({tag, " f1"});
                watch_frame(1'b0, d2, f2, 1, 1, 1, {tag, " f2"});
                sb_check({tag, " f2"});
            end
        join
        @(negedge clk);
        chk({tag, " busy end"}, 32'(busy_a), 32'd0);
        chk({tag, " line end"}, 32'(so_a), 32'd1);
    endtask

    task automatic send_one(input bit sel, input logic [6:0] d, input logic f,
                            input int cpb, input int gap, input string tag);
        exp_q.push_back({f, d});
        host_send(sel, d, f, tag);
        watch_frame(sel, d, f, cpb, gap, 2, tag);
        sb_check(tag);
        @(negedge clk);
        chk({tag, " busy end"}, 32'(bsy(sel)), 32'd0);
        chk({tag, " line end"}, 32'(line(sel)), 32'd1);
    endtask

    initial begin
        logic [6:0] rd1, rd2;
        logic       rf1, rf2;
        rst = 1'b1;
        data_in = '0;
        fpe = 1'b0;
        valid_a = 1'b0;
        valid_b = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset line", 32'(so_a), 32'd1);
        chk("reset ready", 32'(ready_a), 32'd1);
        chk("reset busy", 32'(busy_a), 32'd0);
        chk("reset state", 32'(st_a), 32'd0);
        chk("reset line b", 32'(so_b), 32'd1);
        chk("reset ready b", 32'(ready_b), 32'd1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("idle line%0d", i), 32'(so_a), 32'd1);
            chk($sformatf("idle ready%0d", i), 32'(ready_a), 32'd1);
            chk($sformatf("idle busy%0d", i), 32'(busy_a), 32'd0);
        end

        send_one(1'b0, 7'h55, 1'b0, 1, 1, "w55");
        send_pair(7'h01, 1'b0, 7'h7F, 1'b0, "pair01_7f");
        send_one(1'b0, 7'h55, 1'b1, 1, 1, "w55 forced");
        send_one(1'b1, 7'h2A, 1'b0, 3, 2, "w2a slow");

        for (int n = 0; n < 8; n++) begin
            rd1 = 7'($urandom_range(0, 127));
            rf1 = ($urandom_range(0, 3) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) begin
                rd2 = 7'($urandom_range(0, 127));
                rf2 = ($urandom_range(0, 3) == 0);
                send_pair(rd1, rf1, rd2, rf2, $sformatf("rnd pair%0d", n));
            end else begin
                send_one(n[0], rd1, rf1, n[0] ? 3 : 1, n[0] ? 2 : 1, $sformatf("rnd%0d", n));
            end
        end

        // Reset during D3 of a frame with the next word buffered.
        host_send(1'b0, 7'h33, 1'b0, "rst w1");
        host_send(1'b0, 7'h4C, 1'b0, "rst w2");
        @(negedge clk);
        chk("rst d0 line", 32'(so_a), 32'd1);
        chk("rst buffer full", 32'(ready_a), 32'd0);
        repeat (3) @(negedge clk);
        chk("rst d3 line", 32'(so_a), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst line", 32'(so_a), 32'd1);
        chk("rst busy", 32'(busy_a), 32'd0);
        chk("rst ready", 32'(ready_a), 32'd1);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk($sformatf("post rst line%0d", i), 32'(so_a), 32'd1);
            chk($sformatf("post rst busy%0d", i), 32'(busy_a), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Transmit side of the single-wire, one-bit-per-clock serial link used by the team's serial receiver. Accepts 7-bit words over a valid/ready handshake and serialises each into a fixed frame on `serial_out`: start bit, 7 data bits LSB first, reserved bit, even parity bit, then an idle-high gap. A one-entry holding buffer lets the host queue the next word while a frame is on the wire, so frames go back-to-back with only the programmed gap between them.

## Interface
- `CLKS_PER_BIT`, default 1: clock cycles each frame bit is held; 1 matches the receiver, legal ≥1.
- `GAP_CYCLES`, default 1: idle-high cycles after parity before the next start bit; legal ≥1.
- `clk` input 1: sole clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `data_in` input 7: word to send, sampled on accept.
- `force_parity_err` input 1: sampled with `data_in`; when 1, that frame's parity bit is inverted (test aid).
- `valid` input 1: host offers `data_in`.
- `ready` output 1: block can accept; accept = `valid && ready` at a rising edge.
- `serial_out` output 1: line, idle high, registered.
- `busy` output 1: high while a frame (START..GAP) is in progress.

## Operation
- Frame slots in order: START = 0; D0..D6 = `data_in[0]`..`data_in[6]`; PAD = 0; PARITY = `^data_in ^ force_parity_err`; GAP = 1 for `GAP_CYCLES` cycles.
- Even parity: over D0..D6 plus PARITY, the count of ones is even unless forced.
- The receiver ignores PAD and checks parity against the slot after it. PAD is always driven 0.
- FSM states: IDLE, START, DATA, PAD, PARITY, GAP.
  - IDLE -> START on an accept in IDLE, or when the holding buffer is full.
  - START -> DATA -> PAD -> PARITY -> GAP. Each slot lasts `CLKS_PER_BIT` cycles; DATA lasts 7×`CLKS_PER_BIT`.
  - GAP -> START if the holding buffer is full at the end of GAP; otherwise GAP -> IDLE.
- Datapath: 8-bit shift register {parity, data}. It is loaded on frame start, with parity computed at load, and shifted right once per data bit. A bit counter 0..6 and a clock-divider counter 0..`CLKS_PER_BIT`-1 control slot timing.
- Holding buffer: one entry, stores {`force_parity_err`, `data_in`}.
  - `ready` = !`hold_valid`.
  - An accept in IDLE with an empty buffer loads the shift register directly; the buffer stays empty.
  - An accept in any other state writes the buffer.
  - The buffer drains into the shift register on the IDLE->START or GAP->START transition.
  - An accept in the same cycle the buffer drains is not possible: `ready` is 0 while it is full.
- `valid` without `ready` has no effect. The host holds `data_in` stable until accepted.

## Timing
- Reset values: `serial_out`=1, `ready`=1, `busy`=0, state IDLE, holding buffer empty, counters 0.
- Reset asserted mid-frame: on the next edge the frame is abandoned, the buffer is cleared and `serial_out`=1. No partial frame resumes.
- Latency: an accept at edge k in IDLE gives `serial_out`=0 and `busy`=1 after edge k.
- Frame length: (10 × `CLKS_PER_BIT` + `GAP_CYCLES`) cycles from first START cycle to last GAP cycle.
- Back-to-back: if the buffer is full, the next START follows the last GAP cycle with no IDLE cycle.
- `busy` falls only on entry to IDLE. `ready` falls the edge after a buffer write and rises the edge after the buffer drains.
- `serial_out` changes only on slot boundaries; no glitches, since it is registered.

## Test plan
- Reset, then idle 5 cycles -> `serial_out`=1, `ready`=1, `busy`=0 throughout.
- Send 7'h55, defaults -> line reads 0,1,0,1,0,1,0,1,0,0 then 1. A receiver model outputs `data_out`=7'h55 with `parity_ok_n`=0.
- Send 7'h01 then 7'h7F with `valid` held, defaults -> 7'h7F is accepted during the first frame and `ready`=0 until the buffer drains. The frames are 0,1,0,0,0,0,0,0,0,1,1 and 0,1,1,1,1,1,1,1,0,1,1, exactly 11 cycles apart.
- Send 7'h55 with `force_parity_err`=1 -> parity slot is 1, and the receiver model reports `parity_ok_n`=1.
- `CLKS_PER_BIT`=3, `GAP_CYCLES`=2, send 7'h2A -> each slot is held 3 cycles and the frame lasts 32 cycles. Parity slot = 1 (three ones).
- Assert `rst` for 1 cycle at the 4th data bit of a frame, with the buffer full -> after the next edge `serial_out`=1, `busy`=0 and `ready`=1. No further frame is emitted.
